// File: rtl/snoop_pkg.sv
// ACE snoop channel types shared by the snoop cache controller and its response path.
// Pure type definitions, no logic.
// CR response fields follow the ACE CRRESP bit order, MSB first.
package snoop_pkg;

    typedef logic [3:0] acsnoop_t;

    typedef struct packed {
        logic wasUnique;
        logic isShared;
        logic passDirty;
        logic error;
        logic dataTransfer;
    } crresp_t;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with registered storage and output taken from the head entry.
// Latency: a push in cycle N is visible on data_o / !empty_o in cycle N+1 (no fall-through).
// Backpressure: push is ignored when full, pop is ignored when empty; both may happen together.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] cnt_q;
    dtype            mem_q [DEPTH];
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/snoop_resp_buffer.sv
// Buffers ACE snoop CR responses and CD data beats between the snoop controller and the interconnect.
// Latency: one cycle from upstream handshake to downstream valid; CR and CD drain independently.
// Backpressure: ready drops only when a FIFO is full; ac_stall_o holds off snoops without a CR slot or line credit.
module snoop_resp_buffer
    import snoop_pkg::*;
#(
    parameter int unsigned CrDepth      = 2,
    parameter int unsigned CdLines      = 2,
    parameter int unsigned BeatsPerLine = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cr_valid_i,
    output logic        cr_ready_o,
    input  crresp_t     cr_resp_i,
    input  logic        cd_valid_i,
    output logic        cd_ready_o,
    input  logic [63:0] cd_data_i,
    input  logic        cd_last_i,
    output logic        cr_valid_o,
    input  logic        cr_ready_i,
    output crresp_t     cr_resp_o,
    output logic        cd_valid_o,
    input  logic        cd_ready_i,
    output logic [63:0] cd_data_o,
    output logic        cd_last_o,
    output logic        ac_stall_o,
    output logic        busy_o,
    output logic        proto_err_o
);

    localparam int unsigned BeatCntW = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
    localparam int unsigned ResW     = $clog2(CdLines + 1);
    localparam int unsigned CdDepth  = CdLines * BeatsPerLine;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_beat_t;

    logic              cr_full, cr_empty, cr_push, cr_pop;
    logic              cd_full, cd_empty, cd_push, cd_pop, cd_orphan;
    cd_beat_t          cd_in, cd_head;
    logic [ResW-1:0]   reserved_q;
    logic [BeatCntW-1:0] beat_q;
    logic              res_inc, res_dec, last_mismatch, res_overflow, err_set;

    assign cr_ready_o = !cr_full;
    assign cd_ready_o = !cd_full;
    assign cr_valid_o = !cr_empty;
    assign cd_valid_o = !cd_empty;

    assign cr_push = cr_valid_i && !cr_full;
    assign cr_pop  = cr_valid_o && cr_ready_i;
    // A beat with no outstanding line credit and nothing queued cannot belong to any snoop.
    assign cd_orphan = cd_valid_i && (reserved_q == '0) && cd_empty;
    assign cd_push   = cd_valid_i && !cd_full && !cd_orphan;
    assign cd_pop    = cd_valid_o && cd_ready_i;

    assign cd_in     = '{data: cd_data_i, last: cd_last_i};
    assign cd_data_o = cd_head.data;
    assign cd_last_o = cd_head.last;

    fifo_v3 #(
        .DEPTH (CrDepth),
        .dtype (crresp_t)
    ) i_cr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (cr_full),
        .empty_o (cr_empty),
        .data_i  (cr_resp_i),
        .push_i  (cr_push),
        .data_o  (cr_resp_o),
        .pop_i   (cr_pop)
    );

    fifo_v3 #(
        .DEPTH (CdDepth),
        .dtype (cd_beat_t)
    ) i_cd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (cd_full),
        .empty_o (cd_empty),
        .data_i  (cd_in),
        .push_i  (cd_push),
        .data_o  (cd_head),
        .pop_i   (cd_pop)
    );

    assign res_inc       = cr_push && cr_resp_i.dataTransfer;
    assign res_dec       = cd_pop && cd_head.last;
    assign res_overflow  = res_inc && !res_dec && (reserved_q == ResW'(CdLines));
    assign last_mismatch = cd_push && (cd_last_i != (beat_q == BeatCntW'(BeatsPerLine - 1)));

    assign err_set = (cr_valid_i && cr_full) || (cd_valid_i && cd_full) || cd_orphan
                   || last_mismatch || res_overflow;

    assign ac_stall_o = cr_full || (reserved_q == ResW'(CdLines));
    assign busy_o     = !cr_empty || !cd_empty || (reserved_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reserved_q  <= '0;
            beat_q      <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (res_inc && !res_dec && !res_overflow) begin
                reserved_q <= reserved_q + 1'b1;
            end else if (res_dec && !res_inc && (reserved_q != '0)) begin
                reserved_q <= reserved_q - 1'b1;
            end
            // A mislabelled last still closes the line so the next one starts from beat 0.
            if (cd_push) begin
                if (cd_last_i || (beat_q == BeatCntW'(BeatsPerLine - 1))) begin
                    beat_q <= '0;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
            if (err_set) begin
                proto_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snoop_resp_buffer.sv
// Directed bench for snoop_resp_buffer with CrDepth=2, CdLines=2, BeatsPerLine=2.
module tb_snoop_resp_buffer;
    import snoop_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cr_valid_i, cr_ready_o, cd_valid_i, cd_ready_o, cd_last_i;
    crresp_t     cr_resp_i, cr_resp_o;
    logic [63:0] cd_data_i, cd_data_o;
    logic        cr_valid_o, cr_ready_i, cd_valid_o, cd_ready_i, cd_last_o;
    logic        ac_stall_o, busy_o, proto_err_o;

    int vectors     = 0;
    int miscompares = 0;

    localparam crresp_t CR_A    = 5'b01001;
    localparam crresp_t CR_B    = 5'b00101;
    localparam crresp_t CR_MISS = 5'b00000;
    localparam crresp_t CR_WU   = 5'b10000;

    logic [63:0] bp_data [4];
    logic        bp_last [4];

    snoop_resp_buffer #(
        .CrDepth      (2),
        .CdLines      (2),
        .BeatsPerLine (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cr_valid_i  (cr_valid_i),
        .cr_ready_o  (cr_ready_o),
        .cr_resp_i   (cr_resp_i),
        .cd_valid_i  (cd_valid_i),
        .cd_ready_o  (cd_ready_o),
        .cd_data_i   (cd_data_i),
        .cd_last_i   (cd_last_i),
        .cr_valid_o  (cr_valid_o),
        .cr_ready_i  (cr_ready_i),
        .cr_resp_o   (cr_resp_o),
        .cd_valid_o  (cd_valid_o),
        .cd_ready_i  (cd_ready_i),
        .cd_data_o   (cd_data_o),
        .cd_last_o   (cd_last_o),
        .ac_stall_o  (ac_stall_o),
        .busy_o      (busy_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic l);
        cd_valid_i = 1'b1;
        cd_data_i  = d;
        cd_last_i  = l;
        tick();
        cd_valid_i = 1'b0;
    endtask

    task automatic push_cr(input crresp_t r);
        cr_valid_i = 1'b1;
        cr_resp_i  = r;
        tick();
        cr_valid_i = 1'b0;
    endtask

    initial begin
        bp_data[0] = 64'hA000_0000_0000_0010; bp_last[0] = 1'b0;
        bp_data[1] = 64'hA000_0000_0000_0011; bp_last[1] = 1'b1;
        bp_data[2] = 64'hB000_0000_0000_0020; bp_last[2] = 1'b0;
        bp_data[3] = 64'hB000_0000_0000_0021; bp_last[3] = 1'b1;

        rst_ni = 1'b0;
        cr_valid_i = 1'b0; cr_resp_i = '0; cr_ready_i = 1'b0;
        cd_valid_i = 1'b0; cd_data_i = '0; cd_last_i = 1'b0; cd_ready_i = 1'b0;
        #3;
        check("rst_cr_valid", cr_valid_o, 0);
        check("rst_cd_valid", cd_valid_o, 0);
        check("rst_cr_resp", cr_resp_o, 0);
        check("rst_cd_data", cd_data_o, 0);
        check("rst_cd_last", cd_last_o, 0);
        check("rst_stall", ac_stall_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", proto_err_o, 0);
        check("rst_cr_ready", cr_ready_o, 1);
        check("rst_cd_ready", cd_ready_o, 1);
        #4 rst_ni = 1'b1;

        // Single ReadShared hit with no backpressure
        cr_ready_i = 1'b1; cd_ready_i = 1'b1;
        push_cr(CR_A);
        check("hit_cr_valid", cr_valid_o, 1);
        check("hit_cr_resp", cr_resp_o, CR_A);
        check("hit_busy0", busy_o, 1);
        beat(64'hAAAA_AAAA_0000_0001, 1'b0);
        check("hit_cr_gone", cr_valid_o, 0);
        check("hit_b0_valid", cd_valid_o, 1);
        check("hit_b0_data", cd_data_o, 64'hAAAA_AAAA_0000_0001);
        check("hit_b0_last", cd_last_o, 0);
        beat(64'hBBBB_BBBB_0000_0002, 1'b1);
        check("hit_b1_data", cd_data_o, 64'hBBBB_BBBB_0000_0002);
        check("hit_b1_last", cd_last_o, 1);
        check("hit_busy1", busy_o, 1);
        tick();
        check("hit_cd_gone", cd_valid_o, 0);
        check("hit_busy_end", busy_o, 0);
        check("hit_stall_end", ac_stall_o, 0);
        check("hit_err", proto_err_o, 0);

        // Back-pressure with two data responses
        cr_ready_i = 1'b0; cd_ready_i = 1'b0;
        push_cr(CR_A);
        check("bp_stall_cr1", ac_stall_o, 0);
        push_cr(CR_B);
        check("bp_stall_cr2", ac_stall_o, 1);
        check("bp_cr_ready", cr_ready_o, 0);
        for (int i = 0; i < 4; i++) beat(bp_data[i], bp_last[i]);
        check("bp_cd_ready", cd_ready_o, 0);
        check("bp_cd_valid", cd_valid_o, 1);
        check("bp_head0", cd_data_o, bp_data[0]);
        check("bp_cr_head", cr_resp_o, CR_A);
        tick();
        check("bp_hold", cd_data_o, bp_data[0]);
        cr_ready_i = 1'b1;
        tick();
        check("bp_cr2_resp", cr_resp_o, CR_B);
        tick();
        check("bp_cr_drained", cr_valid_o, 0);
        check("bp_stall_credit", ac_stall_o, 1);
        cr_ready_i = 1'b0; cd_ready_i = 1'b1;
        tick();
        check("bp_head1", cd_data_o, bp_data[1]);
        check("bp_head1_last", cd_last_o, 1);
        check("bp_stall_mid", ac_stall_o, 1);
        tick();
        check("bp_head2", cd_data_o, bp_data[2]);
        check("bp_stall_free", ac_stall_o, 0);
        tick();
        check("bp_head3", cd_data_o, bp_data[3]);
        tick();
        check("bp_cd_drained", cd_valid_o, 0);
        check("bp_busy_end", busy_o, 0);
        cd_ready_i = 1'b0;

        // CR-only misses fill the CR FIFO without taking credit
        push_cr(CR_MISS);
        push_cr(CR_WU);
        check("miss_cr_ready", cr_ready_o, 0);
        check("miss_stall", ac_stall_o, 1);
        check("miss_busy", busy_o, 1);
        cr_ready_i = 1'b1;
        tick();
        check("miss_stall_pop", ac_stall_o, 0);
        check("miss_resp2", cr_resp_o, CR_WU);
        tick();
        check("miss_busy_end", busy_o, 0);

        // Credit increment and decrement in the same cycle while saturated
        push_cr(CR_A);
        push_cr(CR_A);
        check("sim_stall_full", ac_stall_o, 1);
        beat(64'hE0, 1'b0);
        beat(64'hE1, 1'b1);
        cd_ready_i = 1'b1;
        tick();
        check("sim_head_last", cd_last_o, 1);
        cr_valid_i = 1'b1; cr_resp_i = CR_A;
        tick();
        cr_valid_i = 1'b0; cd_ready_i = 1'b0;
        check("sim_stall_held", ac_stall_o, 1);
        check("sim_no_err", proto_err_o, 0);
        check("sim_cr_new", cr_valid_o, 1);
        cd_ready_i = 1'b1;
        beat(64'hF0, 1'b0);
        beat(64'hF1, 1'b1);
        beat(64'hF2, 1'b0);
        beat(64'hF3, 1'b1);
        tick();
        check("sim_busy_end", busy_o, 0);
        check("sim_stall_end", ac_stall_o, 0);
        check("sim_err_end", proto_err_o, 0);

        // Last asserted on the first beat of a line
        push_cr(CR_A);
        beat(64'hC0, 1'b1);
        check("perr_set", proto_err_o, 1);
        check("perr_stored", cd_last_o, 1);
        check("perr_data", cd_data_o, 64'hC0);
        push_cr(CR_A);
        beat(64'hD0, 1'b0);
        beat(64'hD1, 1'b1);
        tick();
        check("perr_sticky", proto_err_o, 1);
        check("perr_busy_end", busy_o, 0);

        // Orphan beat without any line credit
        rst_ni = 1'b0;
        #2;
        check("orph_rst_err", proto_err_o, 0);
        rst_ni = 1'b1;
        tick();
        beat(64'h0BAD, 1'b0);
        check("orph_err", proto_err_o, 1);
        check("orph_dropped", cd_valid_o, 0);
        check("orph_busy", busy_o, 0);

        // Reset in the middle of a buffered line
        rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        tick();
        cr_ready_i = 1'b0; cd_ready_i = 1'b0;
        push_cr(CR_A);
        beat(64'h55AA, 1'b0);
        check("mid_cd_valid", cd_valid_o, 1);
        check("mid_busy", busy_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_cr_valid", cr_valid_o, 0);
        check("mid_rst_cd_valid", cd_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_stall", ac_stall_o, 0);
        check("mid_rst_cr_ready", cr_ready_o, 1);
        check("mid_rst_data", cd_data_o, 0);
        rst_ni = 1'b1;
        tick();
        tick();
        check("mid_post_cd_valid", cd_valid_o, 0);
        check("mid_post_busy", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
